// File: rtl/if_pkg.sv
// Shared constants and entry payload type for the instruction fetch buffer.
package if_pkg;

    localparam int unsigned IF_DEPTH_DEFAULT = 4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_entry_t;

endpackage

// File: rtl/if_buffer_mem.sv
// Entry storage for if_buffer: one synchronous write port, one asynchronous read port.
// The array carries no reset; validity is tracked by the owner's count.
module if_buffer_mem
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = IF_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  if_entry_t                wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output if_entry_t                rdata
);

    if_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_buffer.sv
// Instruction fetch buffer between fetch and decode; in_ready doubles as the PC enable.
// Optional feature: define IF_BUFFER_BYPASS_EN for zero-latency pass-through when empty.
module if_buffer
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = IF_DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_instr,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_pc4,
    output logic [31:0]                out_instr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic          empty;
    logic          push;
    logic          pop;
    logic          bypass_take;
    logic          wr_en;
    logic          rd_adv;
    if_entry_t     in_entry;
    if_entry_t     rd_entry;
    if_entry_t     head;

    assign empty    = (cnt == '0);
    assign in_ready = (cnt != CW'(DEPTH)) && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign in_entry = '{pc: in_pc, instr: in_instr};

    // An entry handed straight to decode from an empty buffer never touches storage.
`ifdef IF_BUFFER_BYPASS_EN
    assign bypass_take = empty && push && out_ready;
`else
    assign bypass_take = 1'b0;
`endif

    assign wr_en  = push && !bypass_take;
    assign rd_adv = pop && !bypass_take;

    if_buffer_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wptr),
        .wdata (in_entry),
        .raddr (rptr),
        .rdata (rd_entry)
    );

    // Pointers wrap naturally at DEPTH; flush and reset share the same clear path.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_adv) begin
                rptr <= rptr + AW'(1);
            end
            case ({wr_en, rd_adv})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Head selection: a nop entry whenever nothing valid is presented.
    always_comb begin
        head      = '{pc: 32'h0, instr: NOP_INSTR};
        out_valid = !empty;
        if (!empty) begin
            head = rd_entry;
        end
`ifdef IF_BUFFER_BYPASS_EN
        if (empty) begin
            out_valid = in_valid && !flush;
            if (in_valid && !flush) begin
                head = in_entry;
            end
        end
`endif
    end

    assign out_pc    = head.pc;
    assign out_pc4   = head.pc + PC_STEP;
    assign out_instr = head.instr;
    assign count     = cnt;

endmodule

// File: tb/tb_if_buffer.sv
// Self-checking bench for if_buffer: directed steps plus random traffic against a queue model.
module tb_if_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_pc;
    logic [31:0]   in_instr;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [31:0]   out_pc4;
    logic [31:0]   out_instr;
    logic [CW-1:0] count;

    if_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_pc4   (out_pc4),
        .out_instr (out_instr),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   seen_4000 = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive, compare against the model, then advance the model at the edge.
    task automatic cycle(input logic rv, input logic iv, input logic [31:0] pc,
                         input logic [31:0] ins, input logic fl, input logic ordy,
                         input bit check);
        int          sz;
        logic        e_rdy;
        logic        e_vld;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        bit          bypassed;
        logic        do_push;
        logic        do_pop;
        ent_t        e;
        reset     = rv;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        flush     = fl;
        out_ready = ordy;
        #2;
        sz    = q.size();
        e_rdy = (sz != DEPTH) && !fl;
        e_vld = (sz > 0);
        e_pc  = 32'h0;
        e_ins = 32'h0;
        bypassed = 1'b0;
        if (sz > 0) begin
            e_pc  = q[0].pc;
            e_ins = q[0].instr;
        end
`ifdef IF_BUFFER_BYPASS_EN
        if (sz == 0) begin
            e_vld = iv && !fl;
            if (e_vld) begin
                e_pc  = pc;
                e_ins = ins;
            end
            bypassed = 1'b1;
        end
`endif
        if (check) begin
            chk("count",     32'(count),     32'(sz));
            chk("in_ready",  32'(in_ready),  32'(e_rdy));
            chk("out_valid", 32'(out_valid), 32'(e_vld));
            chk("out_pc",    out_pc,         e_pc);
            chk("out_pc4",   out_pc4,        e_pc + 32'd4);
            chk("out_instr", out_instr,      e_ins);
        end
        if (out_valid === 1'b1 && out_pc === 32'h4000) seen_4000 = 1'b1;
        do_push = iv && e_rdy;
        do_pop  = e_vld && ordy;
        if (!rv || fl) begin
            q.delete();
        end else if (!(bypassed && do_push && do_pop)) begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e.pc    = pc;
                e.instr = ins;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset held for two edges with fetch asserting valid.
        cycle(1'b0, 1'b1, 32'h2000, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'h2004, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0,    32'h0,         1'b0, 1'b0, 1'b1);

        // Fill to full, then a refused fifth push.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 1'b1, 32'h3000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 32'h3010, 32'hA000_0004, 1'b0, 1'b0, 1'b1);
        chk("full_count", 32'(count), 32'd4);

        // Drain in order, then push across the pointer wrap while consuming.
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 1'b1, 32'h5000 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++)
            cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);

        // Simultaneous push and pop at count 2, then at full.
        cycle(1'b1, 1'b1, 32'h6000, 32'hC000_0000, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 32'h6004, 32'hC000_0001, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 32'h6008, 32'hC000_0002, 1'b0, 1'b1, 1'b1);
        chk("pushpop_count", 32'(count), 32'd2);
        cycle(1'b1, 1'b1, 32'h600C, 32'hC000_0003, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 32'h6010, 32'hC000_0004, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 32'h6014, 32'hC000_0005, 1'b0, 1'b1, 1'b1);
        chk("full_pop_count", 32'(count), 32'd3);

        // Flush with a same-cycle push that must vanish.
        cycle(1'b1, 1'b1, 32'h4000, 32'hD000_0000, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 32'h0,    32'h0,         1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("flushed_pc_seen", 32'(seen_4000), 32'd0);

        // PC+4 wrap at the top of the address space (bypassed when enabled).
        cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 32'hE000_0000, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
`ifdef IF_BUFFER_BYPASS_EN
        chk("bypass_count", 32'(count), 32'd0);
`endif

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 63) != 0),
                  1'($urandom_range(0, 3) != 0),
                  {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} ,
                  $urandom,
                  1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 2) != 0),
                  1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
